// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - core-side and memory-side bus bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int BUS_WIDTH  = 32,
    parameter int RESP_WIDTH = 1
);
    localparam int STRB_WIDTH = BUS_WIDTH / 8;

    // instruction read
    logic                  ir_addr_valid;
    logic                  ir_addr_ready;
    logic [BUS_WIDTH-1:0]  ir_addr;
    logic                  ir_data_valid;
    logic                  ir_data_ready;
    logic [BUS_WIDTH-1:0]  ir_data;

    // data read
    logic                  dr_addr_valid;
    logic                  dr_addr_ready;
    logic [BUS_WIDTH-1:0]  dr_addr;
    logic                  dr_data_valid;
    logic                  dr_data_ready;
    logic [BUS_WIDTH-1:0]  dr_data;

    // data write
    logic                  dw_data_addr_valid;
    logic                  dw_data_addr_ready;
    logic [BUS_WIDTH-1:0]  dw_addr;
    logic [BUS_WIDTH-1:0]  dw_data;
    logic [STRB_WIDTH-1:0] dw_strobe;
    logic                  dw_resp_valid;
    logic                  dw_resp_ready;
    logic [RESP_WIDTH-1:0] dw_resp;

    // shared memory port
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [BUS_WIDTH-1:0]  mem_req_addr;
    logic [BUS_WIDTH-1:0]  mem_req_wdata;
    logic [STRB_WIDTH-1:0] mem_req_strobe;
    logic                  mem_req_write;
    logic                  mem_rsp_valid;
    logic                  mem_rsp_ready;
    logic [BUS_WIDTH-1:0]  mem_rsp_rdata;
    logic [RESP_WIDTH-1:0] mem_rsp_resp;

    // arbiter side
    modport slave (
        input  ir_addr_valid, ir_addr, ir_data_ready,
        output ir_addr_ready, ir_data_valid, ir_data,
        input  dr_addr_valid, dr_addr, dr_data_ready,
        output dr_addr_ready, dr_data_valid, dr_data,
        input  dw_data_addr_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready,
        output dw_data_addr_ready, dw_resp_valid, dw_resp,
        output mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_strobe, mem_req_write,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_rdata, mem_rsp_resp,
        output mem_rsp_ready
    );

    // environment side: core masters plus memory slave
    modport master (
        output ir_addr_valid, ir_addr, ir_data_ready,
        input  ir_addr_ready, ir_data_valid, ir_data,
        output dr_addr_valid, dr_addr, dr_data_ready,
        input  dr_addr_ready, dr_data_valid, dr_data,
        output dw_data_addr_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready,
        input  dw_data_addr_ready, dw_resp_valid, dw_resp,
        input  mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_strobe, mem_req_write,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_rdata, mem_rsp_resp,
        input  mem_rsp_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin 3:1 arbiter for ir/dr/dw onto one memory port
module mem_port_arbiter #(
    parameter int BUS_WIDTH  = 32,
    parameter int RESP_WIDTH = 1
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int STRB_WIDTH = BUS_WIDTH / 8;

    // one-hot master encoding shared by grant, prio and win: bit0 ir, bit1 dr, bit2 dw
    localparam logic [2:0] M_IR = 3'b001;
    localparam logic [2:0] M_DR = 3'b010;
    localparam logic [2:0] M_DW = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [2:0]            grant;
    logic [2:0]            prio;
    logic [2:0]            req;
    logic [2:0]            win;
    logic                  accept;
    logic                  rsp_fire;
    logic                  granted_rsp_ready;

    logic [BUS_WIDTH-1:0]  req_addr;
    logic [BUS_WIDTH-1:0]  req_wdata;
    logic [STRB_WIDTH-1:0] req_strobe;
    logic                  req_write;
    logic [RESP_WIDTH-1:0] rsp_resp;

    assign req = {bus.dw_data_addr_valid, bus.dr_addr_valid, bus.ir_addr_valid};

    // round-robin pick starting at prio, order ir -> dr -> dw -> ir
    always_comb begin
        win = 3'b000;
        unique case (prio)
            M_DR: begin
                if (req[1])      win = M_DR;
                else if (req[2]) win = M_DW;
                else if (req[0]) win = M_IR;
            end
            M_DW: begin
                if (req[2])      win = M_DW;
                else if (req[0]) win = M_IR;
                else if (req[1]) win = M_DR;
            end
            default: begin
                if (req[0])      win = M_IR;
                else if (req[1]) win = M_DR;
                else if (req[2]) win = M_DW;
            end
        endcase
    end

    // readies are gated by rst so nothing is accepted while reset is held
    assign accept            = (state == IDLE) && rst && (win != 3'b000);
    assign granted_rsp_ready = |(grant & {bus.dw_resp_ready, bus.dr_data_ready, bus.ir_data_ready});
    assign rsp_fire          = (state == RSP) && bus.mem_rsp_valid && granted_rsp_ready;

    // state register; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state: one outstanding transaction, IDLE -> REQ -> RSP -> IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)            state_nxt = REQ;
            REQ:     if (bus.mem_req_ready) state_nxt = RSP;
            RSP:     if (rsp_fire)          state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // handshake outputs decoded from state and grant
    always_comb begin
        bus.ir_addr_ready      = 1'b0;
        bus.dr_addr_ready      = 1'b0;
        bus.dw_data_addr_ready = 1'b0;
        bus.mem_req_valid      = 1'b0;
        bus.mem_rsp_ready      = 1'b0;
        bus.ir_data_valid      = 1'b0;
        bus.dr_data_valid      = 1'b0;
        bus.dw_resp_valid      = 1'b0;
        unique case (state)
            IDLE: begin
                bus.ir_addr_ready      = accept && win[0];
                bus.dr_addr_ready      = accept && win[1];
                bus.dw_data_addr_ready = accept && win[2];
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
            end
            RSP: begin
                bus.mem_rsp_ready = granted_rsp_ready;
                bus.ir_data_valid = grant[0] && bus.mem_rsp_valid;
                bus.dr_data_valid = grant[1] && bus.mem_rsp_valid;
                bus.dw_resp_valid = grant[2] && bus.mem_rsp_valid;
            end
            default: ;
        endcase
    end

    // grant/prio bookkeeping and request payload capture at accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant      <= 3'b000;
            prio       <= M_IR;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_strobe <= '0;
            req_write  <= 1'b0;
        end else begin
            if (accept) begin
                grant <= win;
                if (win[2]) begin
                    req_addr   <= bus.dw_addr;
                    req_wdata  <= bus.dw_data;
                    req_strobe <= bus.dw_strobe;
                    req_write  <= 1'b1;
                end else begin
                    req_addr   <= win[1] ? bus.dr_addr : bus.ir_addr;
                    req_wdata  <= '0;
                    req_strobe <= '0;
                    req_write  <= 1'b0;
                end
            end else if (rsp_fire) begin
                grant <= 3'b000;
                // the master after the winner gets first look next time
                prio  <= {grant[1:0], grant[2]};
            end
        end
    end

    assign bus.mem_req_addr   = req_addr;
    assign bus.mem_req_wdata  = req_wdata;
    assign bus.mem_req_strobe = req_strobe;
    assign bus.mem_req_write  = req_write;

    // response payloads pass straight through; only the valids say who owns them
    assign rsp_resp    = bus.mem_rsp_resp;
    assign bus.ir_data = bus.mem_rsp_rdata;
    assign bus.dr_data = bus.mem_rsp_rdata;
    assign bus.dw_resp = rsp_resp;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Three-to-one arbiter sharing a single memory port between the copperv core's instruction-read (ir), data-read (dr) and data-write (dw) buses. It sits between the core and a single-ported memory or bus slave, in place of the simulation crossbar. It uses round-robin arbitration and allows one outstanding transaction at a time. All channels use valid/ready handshakes; a transfer occurs on a cycle where both are high at the rising edge of `clk`.

## Interface
- `BUS_WIDTH`, 32, address/data width
- `RESP_WIDTH`, 1, write response width
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-low (0 = reset)
- `ir_addr_valid` in 1, `ir_addr_ready` out 1, `ir_addr` in BUS_WIDTH: instruction fetch request
- `ir_data_valid` out 1, `ir_data_ready` in 1, `ir_data` out BUS_WIDTH: instruction fetch response
- `dr_addr_valid` in 1, `dr_addr_ready` out 1, `dr_addr` in BUS_WIDTH: data read request
- `dr_data_valid` out 1, `dr_data_ready` in 1, `dr_data` out BUS_WIDTH: data read response
- `dw_data_addr_valid` in 1, `dw_data_addr_ready` out 1, `dw_addr` in BUS_WIDTH, `dw_data` in BUS_WIDTH, `dw_strobe` in BUS_WIDTH/8: write request
- `dw_resp_valid` out 1, `dw_resp_ready` in 1, `dw_resp` out RESP_WIDTH: write response
- `mem_req_valid` out 1, `mem_req_ready` in 1: memory request handshake
- `mem_req_addr` out BUS_WIDTH, `mem_req_wdata` out BUS_WIDTH, `mem_req_strobe` out BUS_WIDTH/8, `mem_req_write` out 1: memory request payload
- `mem_rsp_valid` in 1, `mem_rsp_ready` out 1, `mem_rsp_rdata` in BUS_WIDTH, `mem_rsp_resp` in RESP_WIDTH: memory response

## Operation
- FSM states: IDLE, REQ, RSP. Registers: `grant` (one-hot, 3 bits); `prio` pointer (ir/dr/dw); latched addr/wdata/strobe/write.
- IDLE:
  - Pick a winner among asserted request valids, starting from `prio` in circular order ir→dr→dw→ir.
  - Drive the winner's `*_addr_ready` high combinationally in the same cycle; losers' readies stay 0.
  - On that edge, latch the payload. For ir/dr: `mem_req_write=0`, `wdata=0`, `strobe=0`. For dw: `write=1`, plus `dw_data` and `dw_strobe`.
  - Latch `grant` and go to REQ. With no valids, stay in IDLE.
- REQ:
  - `mem_req_valid=1` with the latched payload; the payload is stable until handshake.
  - On `mem_req_ready`, go to RSP.
- RSP:
  - The granted master's response valid equals `mem_rsp_valid`; the other response valids are 0.
  - `mem_rsp_ready` equals the granted master's response ready.
  - On handshake: go to IDLE, clear `grant`, and set `prio` to the master after the winner (ir→dr, dr→dw, dw→ir).
- Response payload: `ir_data` and `dr_data` are driven from `mem_rsp_rdata`; `dw_resp` is driven from `mem_rsp_resp`. These are combinational pass-throughs, qualified only by their valids.
- No request readies are asserted outside IDLE, so there is exactly one outstanding transaction.
- If `mem_rsp_valid` arrives in IDLE or REQ, `mem_rsp_ready` is 0 and the response is not forwarded (slave protocol violation; not recovered).
- Master back-pressure in RSP, i.e. ready low, holds the FSM in RSP indefinitely.

## Timing
- While `rst`=0, these outputs are all 0: every valid and ready output, `mem_req_addr`, `mem_req_wdata`, `mem_req_strobe`, `mem_req_write`, and `grant`. State is IDLE and `prio`=ir.
- Reset mid-transaction aborts immediately to IDLE. No response is delivered for the aborted transfer.
- The first accept is possible on the first rising edge after `rst` rises.
- Latency:
  - Request accepted at edge N (IDLE).
  - `mem_req_valid` high during cycle N+1.
  - Earliest `mem_req` handshake at edge N+1.
  - Earliest response handshake at edge N+2.
  - Back in IDLE for cycle N+3.
  - Minimum 3 cycles per transaction at a zero-wait slave.
- Simultaneous valids are resolved only by `prio`. A master whose valid stays asserted is granted within 3 transactions (starvation-free).
- A master dropping its request valid before acceptance is legal; arbitration uses the current cycle's valids only.
- `mem_rsp_valid` and the master's ready in the same cycle as entry into RSP form a valid handshake.

## Test plan
- Single fetch with a zero-wait slave:
  - Stimulus: `ir_addr`=0x100 at reset exit; slave returns 0x00000013.
  - Required: `ir_addr_ready` at edge N; `mem_req_addr`=0x100 with `write`=0 at N+1; `ir_data`=0x00000013 with `ir_data_valid` at N+2; dr and dw response valids stay 0.
- Write:
  - Stimulus: `dw_addr`=0x8004, `dw_data`=0x41, `dw_strobe`=4'b0001; slave `resp`=1.
  - Required: `mem_req_write`=1, `wdata`=0x41, `strobe`=0x1; `dw_resp_valid`=1 with `dw_resp`=1.
- Round-robin with ir, dr and dw valid continuously after reset:
  - Required: grant order ir, dr, dw, ir, dr, dw.
  - Required: each request accepted exactly once per grant, with its own address on `mem_req_addr`.
- Back-pressure:
  - Stimulus: slave `mem_req_ready` low for 5 cycles, then `dr_data_ready` low for 4 cycles.
  - Required: `mem_req` payload stable throughout; FSM stays in RSP; `dr_data_valid` is held; no new request readies are asserted.
- Reset mid-operation:
  - Stimulus: assert `rst`=0 during REQ of a dw request.
  - Required: `mem_req_valid` goes 0 asynchronously; after release, a pending ir request is granted first (`prio`=ir).
- Spurious response:
  - Stimulus: `mem_rsp_valid`=1 while in IDLE.
  - Required: `mem_rsp_ready`=0 and all master response valids stay 0.
